// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU functions, condition codes,
// register and status codes, plus the control half of the E->M register.
package y86_pkg;

   localparam logic [3:0] IHALT  = 4'h0;
   localparam logic [3:0] INOP   = 4'h1;
   localparam logic [3:0] CMOVXX = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   // Width-independent fields of the M register; data fields live beside it.
   typedef struct packed {
      logic [2:0] stat;
      logic [3:0] icode;
      logic       cnd;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
   } m_ctl_t;

   localparam m_ctl_t M_CTL_BUBBLE = '{stat: SAOK, icode: INOP, cnd: 1'b0,
                                       dst_e: RNONE, dst_m: RNONE};

endpackage

// File: rtl/y86_execute_ccreg_if.sv
// Signal bundle between decode/control and the execute stage with its E->M register.
interface y86_execute_ccreg_if #(parameter int DATA_W = 64);

   logic [2:0]        E_stat;
   logic [3:0]        E_icode;
   logic [3:0]        E_ifun;
   logic [DATA_W-1:0] E_valA;
   logic [DATA_W-1:0] E_valB;
   logic [DATA_W-1:0] E_valC;
   logic [3:0]        E_dstE;
   logic [3:0]        E_dstM;
   logic              m_exc;
   logic              W_exc;
   logic              M_stall;
   logic              M_bubble;

   logic              e_Cnd;
   logic [DATA_W-1:0] e_valE;
   logic [3:0]        e_dstE;
   logic [2:0]        M_stat;
   logic [3:0]        M_icode;
   logic              M_Cnd;
   logic [DATA_W-1:0] M_valE;
   logic [DATA_W-1:0] M_valA;
   logic [3:0]        M_dstE;
   logic [3:0]        M_dstM;
   logic              cc_zf;
   logic              cc_sf;
   logic              cc_of;

   // No valid/ready: E_* is consumed every edge. M_stall holds M (and wins over
   // M_bubble); M_bubble alone loads a NOP; otherwise M loads the E results.
   modport master (
      output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      output m_exc, W_exc, M_stall, M_bubble,
      input  e_Cnd, e_valE, e_dstE,
      input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
      input  cc_zf, cc_sf, cc_of
   );

   modport slave (
      input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      input  m_exc, W_exc, M_stall, M_bubble,
      output e_Cnd, e_valE, e_dstE,
      output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
      output cc_zf, cc_sf, cc_of
   );

endinterface

// File: rtl/y86_cond_eval.sv
// Branch / conditional-move predicate from a set of condition flags.
module y86_cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   output logic       cnd
);

   logic lt;

   always_comb begin
      cnd = 1'b0;
      lt  = sf ^ of;
      case (ifun)
         C_YES:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/y86_execute_ccreg.sv
// Y86 execute stage: ALU, exception-gated condition-code register,
// jXX/cmovXX evaluation on the registered flags, and the E->M pipeline register.
module y86_execute_ccreg
   import y86_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int STK_STEP = DATA_W / 8
) (
   input logic                  clk,
   input logic                  reset,
   y86_execute_ccreg_if.slave   bus
);

   localparam int MSB = DATA_W - 1;
   localparam logic [DATA_W-1:0] STEP = DATA_W'(STK_STEP);

   logic [DATA_W-1:0] a, b, c;
   logic [DATA_W-1:0] alu_r;
   logic              alu_of;
   logic [DATA_W-1:0] val_e;
   logic              set_cc;
   logic              zf_q, sf_q, of_q;
   logic              cnd_raw;
   logic              cnd;
   logic [3:0]        dst_e;
   m_ctl_t            m_ctl_q;
   logic [DATA_W-1:0] m_val_e_q;
   logic [DATA_W-1:0] m_val_a_q;

   assign a = bus.E_valA;
   assign b = bus.E_valB;
   assign c = bus.E_valC;

   always_comb begin
      alu_r  = '0;
      alu_of = 1'b0;
      case (bus.E_ifun)
         ALU_ADD: begin
            alu_r  = b + a;
            alu_of = (a[MSB] == b[MSB]) && (alu_r[MSB] != b[MSB]);
         end
         ALU_SUB: begin
            alu_r  = b - a;
            alu_of = (a[MSB] != b[MSB]) && (alu_r[MSB] != b[MSB]);
         end
         ALU_AND: alu_r = b & a;
         ALU_XOR: alu_r = b ^ a;
         default: alu_r = '0;
      endcase
   end

   always_comb begin
      val_e = '0;
      case (bus.E_icode)
         IRMOVQ:         val_e = c;
         RMMOVQ, MRMOVQ: val_e = b + c;
         CMOVXX:         val_e = a;
         CALL, PUSHQ:    val_e = b - STEP;
         RET, POPQ:      val_e = b + STEP;
         OPQ:            val_e = alu_r;
         default:        val_e = '0;
      endcase
   end

   // Exceptions further down the pipe must not leak flag updates from younger ops.
   assign set_cc = (bus.E_icode == OPQ) && (bus.E_ifun <= ALU_XOR) &&
                   !bus.m_exc && !bus.W_exc && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         zf_q <= 1'b1;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else if (set_cc) begin
         zf_q <= (alu_r == '0);
         sf_q <= alu_r[MSB];
         of_q <= alu_of;
      end
   end

   y86_cond_eval u_cond (
      .ifun (bus.E_ifun),
      .zf   (zf_q),
      .sf   (sf_q),
      .of   (of_q),
      .cnd  (cnd_raw)
   );

   assign cnd   = ((bus.E_icode == JXX) || (bus.E_icode == CMOVXX)) ? cnd_raw : 1'b0;
   assign dst_e = ((bus.E_icode == CMOVXX) && !cnd) ? RNONE : bus.E_dstE;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_ctl_q   <= M_CTL_BUBBLE;
         m_val_e_q <= '0;
         m_val_a_q <= '0;
      end else if (bus.M_stall) begin
         m_ctl_q   <= m_ctl_q;
         m_val_e_q <= m_val_e_q;
         m_val_a_q <= m_val_a_q;
      end else if (bus.M_bubble) begin
         m_ctl_q   <= M_CTL_BUBBLE;
         m_val_e_q <= '0;
         m_val_a_q <= '0;
      end else begin
         m_ctl_q   <= '{stat: bus.E_stat, icode: bus.E_icode, cnd: cnd,
                        dst_e: dst_e, dst_m: bus.E_dstM};
         m_val_e_q <= val_e;
         m_val_a_q <= a;
      end
   end

   assign bus.e_Cnd   = cnd;
   assign bus.e_valE  = val_e;
   assign bus.e_dstE  = dst_e;
   assign bus.M_stat  = m_ctl_q.stat;
   assign bus.M_icode = m_ctl_q.icode;
   assign bus.M_Cnd   = m_ctl_q.cnd;
   assign bus.M_valE  = m_val_e_q;
   assign bus.M_valA  = m_val_a_q;
   assign bus.M_dstE  = m_ctl_q.dst_e;
   assign bus.M_dstM  = m_ctl_q.dst_m;
   assign bus.cc_zf   = zf_q;
   assign bus.cc_sf   = sf_q;
   assign bus.cc_of   = of_q;

endmodule

// File: tb/tb_y86_execute_ccreg.sv
// Bench for y86_execute_ccreg: 64-bit and 32-bit instances, directed scenarios
// plus random traffic checked against a flag/arithmetic reference model.
module tb_y86_execute_ccreg;

   localparam logic [3:0] K_NOP = 4'h1, K_CMOV = 4'h2, K_IRMOV = 4'h3, K_RMMOV = 4'h4;
   localparam logic [3:0] K_MRMOV = 4'h5, K_OPQ = 4'h6, K_JXX = 4'h7, K_CALL = 4'h8;
   localparam logic [3:0] K_RET = 4'h9, K_PUSH = 4'hA, K_POP = 4'hB, K_RNONE = 4'hF;
   localparam logic [2:0] K_SAOK = 3'd1;

   logic clk = 1'b0;
   logic s_reset;
   always #5 clk = ~clk;

   logic [2:0]  s_stat;
   logic [3:0]  s_icode, s_ifun, s_dstE, s_dstM;
   logic [63:0] s_valA, s_valB, s_valC;
   logic        s_mexc, s_wexc, s_stall, s_bubble;

   y86_execute_ccreg_if #(.DATA_W(64)) if64 ();
   y86_execute_ccreg_if #(.DATA_W(32)) if32 ();

   y86_execute_ccreg #(.DATA_W(64), .STK_STEP(8)) u64 (.clk(clk), .reset(s_reset), .bus(if64));
   y86_execute_ccreg #(.DATA_W(32), .STK_STEP(4)) u32 (.clk(clk), .reset(s_reset), .bus(if32));

   assign if64.E_stat = s_stat;     assign if32.E_stat = s_stat;
   assign if64.E_icode = s_icode;   assign if32.E_icode = s_icode;
   assign if64.E_ifun = s_ifun;     assign if32.E_ifun = s_ifun;
   assign if64.E_valA = s_valA;     assign if32.E_valA = s_valA[31:0];
   assign if64.E_valB = s_valB;     assign if32.E_valB = s_valB[31:0];
   assign if64.E_valC = s_valC;     assign if32.E_valC = s_valC[31:0];
   assign if64.E_dstE = s_dstE;     assign if32.E_dstE = s_dstE;
   assign if64.E_dstM = s_dstM;     assign if32.E_dstM = s_dstM;
   assign if64.m_exc = s_mexc;      assign if32.m_exc = s_mexc;
   assign if64.W_exc = s_wexc;      assign if32.W_exc = s_wexc;
   assign if64.M_stall = s_stall;   assign if32.M_stall = s_stall;
   assign if64.M_bubble = s_bubble; assign if32.M_bubble = s_bubble;

   int w = 64;
   int n_assert = 0;
   int n_fail = 0;

   logic        o_cnd, o_mcnd, o_zf, o_sf, o_of;
   logic [63:0] o_valE, o_mvalE, o_mvalA;
   logic [3:0]  o_dstE, o_micode, o_mdstE, o_mdstM;
   logic [2:0]  o_mstat;

   always_comb begin
      if (w == 64) begin
         o_cnd = if64.e_Cnd; o_valE = if64.e_valE; o_dstE = if64.e_dstE;
         o_mstat = if64.M_stat; o_micode = if64.M_icode; o_mcnd = if64.M_Cnd;
         o_mvalE = if64.M_valE; o_mvalA = if64.M_valA;
         o_mdstE = if64.M_dstE; o_mdstM = if64.M_dstM;
         o_zf = if64.cc_zf; o_sf = if64.cc_sf; o_of = if64.cc_of;
      end else begin
         o_cnd = if32.e_Cnd; o_valE = {32'd0, if32.e_valE}; o_dstE = if32.e_dstE;
         o_mstat = if32.M_stat; o_micode = if32.M_icode; o_mcnd = if32.M_Cnd;
         o_mvalE = {32'd0, if32.M_valE}; o_mvalA = {32'd0, if32.M_valA};
         o_mdstE = if32.M_dstE; o_mdstM = if32.M_dstM;
         o_zf = if32.cc_zf; o_sf = if32.cc_sf; o_of = if32.cc_of;
      end
   end

   // Reference state
   logic        r_zf, r_sf, r_of;
   logic [2:0]  r_mstat;
   logic [3:0]  r_micode, r_mdstE, r_mdstM;
   logic        r_mcnd;
   logic [63:0] r_mvalE, r_mvalA;
   logic        x_cnd, x_setcc, f_zf, f_sf, f_of;
   logic [63:0] x_valE;
   logic [3:0]  x_dstE;

   function automatic logic [63:0] msk(input logic [63:0] v);
      return (w == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
   endfunction

   function automatic logic signed [127:0] sx(input logic [63:0] v);
      if (w == 64) return {{64{v[63]}}, v};
      return {{96{v[31]}}, v[31:0]};
   endfunction

   function automatic logic [63:0] max_pos();
      return (w == 64) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (w=%0d) observed=%h expected=%h", tag, w, obs, exp);
      end
   endtask

   task automatic model_comb();
      logic [63:0] a, b, c, stp;
      logic signed [127:0] t, hi, lo, one;
      logic lt;
      a = msk(s_valA); b = msk(s_valB); c = msk(s_valC);
      stp = 64'(w / 8);
      one = 1;
      hi = (one <<< (w - 1)) - 1;
      lo = -(one <<< (w - 1));
      t = 0;
      x_valE = 64'd0; x_setcc = 1'b0; f_zf = 1'b0; f_sf = 1'b0; f_of = 1'b0;
      case (s_icode)
         K_IRMOV:          x_valE = c;
         K_RMMOV, K_MRMOV: x_valE = msk(b + c);
         K_CMOV:           x_valE = a;
         K_CALL, K_PUSH:   x_valE = msk(b - stp);
         K_RET, K_POP:     x_valE = msk(b + stp);
         K_OPQ: if (s_ifun <= 4'd3) begin
            case (s_ifun)
               4'd0:    t = sx(b) + sx(a);
               4'd1:    t = sx(b) - sx(a);
               4'd2:    t = sx(b & a);
               default: t = sx(b ^ a);
            endcase
            x_valE  = msk(t[63:0]);
            f_of    = (s_ifun <= 4'd1) && (t > hi || t < lo);
            f_zf    = (x_valE == 64'd0);
            f_sf    = x_valE[w-1];
            x_setcc = !s_mexc && !s_wexc && !s_reset;
         end
         default: x_valE = 64'd0;
      endcase
      lt = (r_sf != r_of);
      case (s_ifun)
         4'd0: x_cnd = 1'b1;
         4'd1: x_cnd = lt || r_zf;
         4'd2: x_cnd = lt;
         4'd3: x_cnd = r_zf;
         4'd4: x_cnd = !r_zf;
         4'd5: x_cnd = !lt;
         4'd6: x_cnd = !lt && !r_zf;
         default: x_cnd = 1'b0;
      endcase
      if (s_icode != K_JXX && s_icode != K_CMOV) x_cnd = 1'b0;
      x_dstE = (s_icode == K_CMOV && !x_cnd) ? K_RNONE : s_dstE;
   endtask

   task automatic model_edge();
      if (s_reset) begin
         r_zf = 1'b1; r_sf = 1'b0; r_of = 1'b0;
      end else if (x_setcc) begin
         r_zf = f_zf; r_sf = f_sf; r_of = f_of;
      end
      if (s_reset || (!s_stall && s_bubble)) begin
         r_mstat = K_SAOK; r_micode = K_NOP; r_mcnd = 1'b0;
         r_mvalE = 64'd0; r_mvalA = 64'd0; r_mdstE = K_RNONE; r_mdstM = K_RNONE;
      end else if (!s_stall) begin
         r_mstat = s_stat; r_micode = s_icode; r_mcnd = x_cnd;
         r_mvalE = x_valE; r_mvalA = msk(s_valA); r_mdstE = x_dstE; r_mdstM = s_dstM;
      end
   endtask

   // Inputs are already set (at a negedge); check comb, clock once, check state.
   task automatic step();
      #1;
      model_comb();
      chk("e_Cnd", {63'd0, o_cnd}, {63'd0, x_cnd});
      chk("e_valE", o_valE, x_valE);
      chk("e_dstE", {60'd0, o_dstE}, {60'd0, x_dstE});
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("cc_zf", {63'd0, o_zf}, {63'd0, r_zf});
      chk("cc_sf", {63'd0, o_sf}, {63'd0, r_sf});
      chk("cc_of", {63'd0, o_of}, {63'd0, r_of});
      chk("M_stat", {61'd0, o_mstat}, {61'd0, r_mstat});
      chk("M_icode", {60'd0, o_micode}, {60'd0, r_micode});
      chk("M_Cnd", {63'd0, o_mcnd}, {63'd0, r_mcnd});
      chk("M_valE", o_mvalE, r_mvalE);
      chk("M_valA", o_mvalA, r_mvalA);
      chk("M_dstE", {60'd0, o_mdstE}, {60'd0, r_mdstE});
      chk("M_dstM", {60'd0, o_mdstM}, {60'd0, r_mdstM});
   endtask

   task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc);
      s_stat = K_SAOK; s_icode = icode; s_ifun = ifun;
      s_valA = va; s_valB = vb; s_valC = vc;
      s_dstE = 4'h3; s_dstM = 4'h5;
      s_mexc = 1'b0; s_wexc = 1'b0; s_stall = 1'b0; s_bubble = 1'b0; s_reset = 1'b0;
   endtask

   task automatic run_phase();
      logic [63:0] mp;
      mp = max_pos();
      // Reset then idle
      drive(K_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
      s_reset = 1'b1; s_dstE = K_RNONE; s_dstM = K_RNONE;
      step();
      chk("reset_zf", {63'd0, o_zf}, 64'd1);
      chk("reset_M_icode", {60'd0, o_micode}, {60'd0, K_NOP});
      chk("reset_M_dstE", {60'd0, o_mdstE}, {60'd0, K_RNONE});
      drive(K_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
      step();
      // sub 5-5 then je / jne
      drive(K_OPQ, 4'h1, 64'd5, 64'd5, 64'd0);
      #1 chk("sub_valE", o_valE, 64'd0);
      step();
      chk("sub_zf", {63'd0, o_zf}, 64'd1);
      drive(K_JXX, 4'h3, 64'd0, 64'd0, 64'h40);
      #1 chk("je_cnd", {63'd0, o_cnd}, 64'd1);
      step();
      drive(K_JXX, 4'h4, 64'd0, 64'd0, 64'h40);
      #1 chk("jne_cnd", {63'd0, o_cnd}, 64'd0);
      step();
      // signed overflow on add, then cmovl
      drive(K_OPQ, 4'h0, mp, mp, 64'd0);
      #1 chk("add_ovf_valE", o_valE, msk(64'hFFFF_FFFF_FFFF_FFFE));
      step();
      chk("add_ovf_sf", {63'd0, o_sf}, 64'd1);
      chk("add_ovf_of", {63'd0, o_of}, 64'd1);
      drive(K_CMOV, 4'h2, 64'h1234, 64'd0, 64'd0);
      #1 chk("cmovl_dstE", {60'd0, o_dstE}, {60'd0, K_RNONE});
      step();
      chk("cmovl_M_dstE", {60'd0, o_mdstE}, {60'd0, K_RNONE});
      // xor under a downstream exception leaves CC alone
      drive(K_OPQ, 4'h3, 64'hF0, 64'hF0, 64'd0);
      s_mexc = 1'b1;
      #1 chk("xor_exc_valE", o_valE, 64'd0);
      step();
      chk("xor_exc_of", {63'd0, o_of}, 64'd1);
      drive(K_OPQ, 4'h2, 64'h0, 64'h5, 64'd0);
      s_wexc = 1'b1;
      step();
      // stack adjust
      drive(K_PUSH, 4'h0, 64'd0, 64'h100, 64'd0);
      #1 chk("push_valE", o_valE, 64'h100 - 64'(w / 8));
      step();
      drive(K_POP, 4'h0, 64'd0, 64'h100, 64'd0);
      #1 chk("pop_valE", o_valE, 64'h100 + 64'(w / 8));
      step();
      // stall dominates bubble, then bubble alone
      for (int i = 0; i < 2; i++) begin
         drive(K_IRMOV, 4'h0, 64'd7, 64'd9, 64'hABC + 64'(i));
         s_stall = 1'b1; s_bubble = 1'b1;
         step();
         chk("stall_hold_icode", {60'd0, o_micode}, {60'd0, K_POP});
      end
      drive(K_IRMOV, 4'h0, 64'd7, 64'd9, 64'hABC);
      s_bubble = 1'b1;
      step();
      chk("bubble_icode", {60'd0, o_micode}, {60'd0, K_NOP});
      // reset in the middle of a flag-setting op
      drive(K_OPQ, 4'h1, 64'd9, 64'd3, 64'd0);
      s_reset = 1'b1;
      step();
      chk("midreset_zf", {63'd0, o_zf}, 64'd1);
      // random traffic
      for (int i = 0; i < 200; i++) begin
         s_stat = 3'($urandom_range(1, 4));
         s_icode = 4'($urandom_range(0, 15));
         s_ifun = 4'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: s_valA = mp;
            1: s_valA = ~mp;
            default: s_valA = {$urandom, $urandom};
         endcase
         s_valB = ($urandom_range(0, 3) == 0) ? s_valA : {$urandom, $urandom};
         s_valC = {$urandom, $urandom};
         s_dstE = 4'($urandom_range(0, 15));
         s_dstM = 4'($urandom_range(0, 15));
         s_mexc = ($urandom_range(0, 7) == 0);
         s_wexc = ($urandom_range(0, 7) == 0);
         s_stall = ($urandom_range(0, 7) == 0);
         s_bubble = ($urandom_range(0, 7) == 0);
         s_reset = ($urandom_range(0, 49) == 0);
         step();
      end
   endtask

   initial begin
      drive(K_NOP, 4'h0, 64'd0, 64'd0, 64'd0);
      s_reset = 1'b1;
      @(negedge clk);
      w = 64;
      run_phase();
      w = 32;
      run_phase();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
